// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: lets requesters A and B share one synchronous dual-port RAM.
// The write port and the read port each have their own round-robin arbiter, so
// one write and one read can issue in the same cycle. When both ports target the
// same address, the arbiters take turns: first the write goes and the read waits,
// then the read goes and the write waits. Read data is returned to the requester
// that issued the read, with a one-cycle rvalid pulse.
module ram_port_arbiter #(
    parameter int unsigned Width   = 8,
    parameter int unsigned Depth   = 16,
    parameter int unsigned AddrBus = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               a_req_i,
    input  logic               a_we_i,
    input  logic [AddrBus-1:0] a_addr_i,
    input  logic [Width-1:0]   a_din_i,
    output logic               a_gnt_o,
    output logic               a_rvalid_o,
    output logic [Width-1:0]   a_dout_o,

    input  logic               b_req_i,
    input  logic               b_we_i,
    input  logic [AddrBus-1:0] b_addr_i,
    input  logic [Width-1:0]   b_din_i,
    output logic               b_gnt_o,
    output logic               b_rvalid_o,
    output logic [Width-1:0]   b_dout_o,

    output logic [Width-1:0]   ram_din_o,
    output logic               ram_we_o,
    output logic [AddrBus-1:0] ram_wr_o,
    output logic               ram_re_o,
    output logic [AddrBus-1:0] ram_rd_o,
    input  logic [Width-1:0]   ram_dout_i
);

    // Pointer encoding: 0 = A has priority, 1 = B has priority.
    logic wr_ptr_q, wr_ptr_d;
    logic rd_ptr_q, rd_ptr_d;
    logic defer_q, defer_d;
    logic rd_own_q, rd_own_d;
    logic rd_pend_q, rd_pend_d;

    logic               wr_cand_a, wr_cand_b, wr_valid, wr_sel_b, wr_go;
    logic               rd_cand_a, rd_cand_b, rd_valid, rd_sel_b, rd_go;
    logic               hazard;
    logic [AddrBus-1:0] wr_addr, rd_addr;
    logic [Width-1:0]   wr_data;

    // Select a winner on each port, resolve same-address conflicts, and drive the RAM.
    always_comb begin
        wr_cand_a = a_req_i & a_we_i;
        wr_cand_b = b_req_i & b_we_i;
        rd_cand_a = a_req_i & ~a_we_i;
        rd_cand_b = b_req_i & ~b_we_i;

        wr_valid  = wr_cand_a | wr_cand_b;
        rd_valid  = rd_cand_a | rd_cand_b;
        // B wins if it is the only candidate, or if both are candidates and B has priority.
        wr_sel_b  = wr_cand_b & (~wr_cand_a | wr_ptr_q);
        rd_sel_b  = rd_cand_b & (~rd_cand_a | rd_ptr_q);

        wr_addr   = wr_sel_b ? b_addr_i : a_addr_i;
        wr_data   = wr_sel_b ? b_din_i  : a_din_i;
        rd_addr   = rd_sel_b ? b_addr_i : a_addr_i;

        hazard    = wr_valid & rd_valid & (wr_addr == rd_addr);
        // defer_q selects which side of a hazard is allowed through this cycle.
        wr_go     = rst_ni & wr_valid & ~(hazard & defer_q);
        rd_go     = rst_ni & rd_valid & ~(hazard & ~defer_q);

        ram_we_o  = wr_go;
        ram_wr_o  = wr_addr;
        ram_din_o = wr_data;
        ram_re_o  = rd_go;
        ram_rd_o  = rd_addr;

        a_gnt_o   = (wr_go & ~wr_sel_b) | (rd_go & ~rd_sel_b);
        b_gnt_o   = (wr_go & wr_sel_b)  | (rd_go & rd_sel_b);
    end

    // Compute the next state: advance the pointers, toggle deferral, track the pending read.
    always_comb begin
        wr_ptr_d  = wr_go ? ~wr_sel_b : wr_ptr_q;
        rd_ptr_d  = rd_go ? ~rd_sel_b : rd_ptr_q;
        defer_d   = hazard & ~defer_q;
        rd_pend_d = rd_go;
        rd_own_d  = rd_go ? rd_sel_b : rd_own_q;
    end

    // State registers, with a synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            defer_q   <= 1'b0;
            rd_own_q  <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            defer_q   <= defer_d;
            rd_own_q  <= rd_own_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Route the read return to its owner. Gating with rst_ni drops any read in flight
    // when reset is asserted.
    always_comb begin
        a_rvalid_o = rst_ni & rd_pend_q & ~rd_own_q;
        b_rvalid_o = rst_ni & rd_pend_q & rd_own_q;
        a_dout_o   = ram_dout_i;
        b_dout_o   = ram_dout_i;
    end

endmodule
